// File: rtl/gate_apply_array.sv
// ---------------------------------------------------------------------------
// gate_apply_array
//   Applies a programmable 2x2 complex unitary U to LANES amplitude pairs
//   (a, b) per beat:  out_a = u00*a + u01*b,  out_b = u10*a + u11*b.
//   Three-stage pipeline (multiply / accumulate / round+saturate) with a
//   valid/ready stream handshake, per-lane bypass and a sticky saturation
//   flag. Sits between the state-vector read port and its write-back path.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_coef_load       latch i_coef_in into the matrix registers
//   i_coef_in         {u00.re,u00.im,u01.re,u01.im,u10.re,u10.im,u11.re,u11.im}
//   i_in_valid        input beat valid
//   o_in_ready        input accepted when i_in_valid && o_in_ready
//   i_in_a, i_in_b    per-lane amplitudes, lane k at [k*2*DATA_W +: 2*DATA_W],
//                     real part in the upper DATA_W bits
//   i_in_bypass       per-lane identity (controlled-gate off lanes)
//   o_out_valid       output beat valid
//   i_out_ready       consumer ready
//   o_out_a, o_out_b  results, same packing as the inputs
//   o_sat_flag        sticky: a non-bypassed component clamped
//   i_sat_clear       clear o_sat_flag (wins over a same-cycle set)
//   o_busy            any pipeline stage holds a valid beat
// ---------------------------------------------------------------------------

// Per-lane datapath. All three stages advance on i_en; o_sat reports a clamp
// in the beat currently leaving S2 (the top qualifies it with valid/enable).
module gate_apply_lane #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [8*DATA_W-1:0]   i_coef,
    input  logic [2*DATA_W-1:0]   i_a,
    input  logic [2*DATA_W-1:0]   i_b,
    input  logic                  i_bypass,
    output logic [2*DATA_W-1:0]   o_a,
    output logic [2*DATA_W-1:0]   o_b,
    output logic                  o_sat
);
    localparam int PW = 2 * DATA_W;   // product width
    localparam int SW = PW + 2;       // sum of four products
    localparam int RW = PW + 3;       // headroom for the rounding add

    localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [RW-1:0] MAXV = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic signed [PW-1:0] mul(input logic signed [DATA_W-1:0] x,
                                                 input logic signed [DATA_W-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = PW'(x);
        ye = PW'(y);
        return xe * ye;
    endfunction

    // u index: 0..3 -> u00.re,u00.im,u01.re,u01.im ; 4..7 -> u10/u11
    logic signed [DATA_W-1:0] w_u [8];
    logic signed [DATA_W-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [PW-1:0]     w_p [2][8];
    logic signed [PW-1:0]     r_p [2][8];
    logic [PW-1:0]            r_a1, r_b1, r_a2, r_b2;
    logic                     r_byp1, r_byp2;
    // sums: 0 = out_a.re, 1 = out_a.im, 2 = out_b.re, 3 = out_b.im
    logic signed [SW-1:0]     w_s [4];
    logic signed [SW-1:0]     r_s [4];
    logic signed [RW-1:0]     w_rnd [4];
    logic signed [RW-1:0]     w_sh [4];
    logic [DATA_W-1:0]        w_q [4];
    logic [3:0]               w_clip;
    logic [PW-1:0]            r_oa, r_ob;

    always_comb begin
        for (int j = 0; j < 8; j++) w_u[j] = i_coef[(7-j)*DATA_W +: DATA_W];
    end

    assign w_ar = i_a[PW-1:DATA_W];
    assign w_ai = i_a[DATA_W-1:0];
    assign w_br = i_b[PW-1:DATA_W];
    assign w_bi = i_b[DATA_W-1:0];

    // Terms 0..3 feed the real sum, 4..7 the imaginary sum.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            w_p[o][0] = mul(w_u[4*o],   w_ar);
            w_p[o][1] = mul(w_u[4*o+1], w_ai);
            w_p[o][2] = mul(w_u[4*o+2], w_br);
            w_p[o][3] = mul(w_u[4*o+3], w_bi);
            w_p[o][4] = mul(w_u[4*o],   w_ai);
            w_p[o][5] = mul(w_u[4*o+1], w_ar);
            w_p[o][6] = mul(w_u[4*o+2], w_bi);
            w_p[o][7] = mul(w_u[4*o+3], w_br);
        end
    end

    always_comb begin
        for (int o = 0; o < 2; o++) begin
            w_s[2*o]   = SW'(r_p[o][0]) - SW'(r_p[o][1]) + SW'(r_p[o][2]) - SW'(r_p[o][3]);
            w_s[2*o+1] = SW'(r_p[o][4]) + SW'(r_p[o][5]) + SW'(r_p[o][6]) + SW'(r_p[o][7]);
        end
    end

    // Round half up, then clamp to the DATA_W signed range.
    always_comb begin
        w_clip = '0;
        for (int i = 0; i < 4; i++) begin
            w_rnd[i] = RW'(r_s[i]) + HALF;
            w_sh[i]  = w_rnd[i] >>> FRAC_W;
            w_q[i]   = w_sh[i][DATA_W-1:0];
            if (w_sh[i] > MAXV) begin
                w_q[i]    = MAXV[DATA_W-1:0];
                w_clip[i] = 1'b1;
            end else if (w_sh[i] < MINV) begin
                w_q[i]    = MINV[DATA_W-1:0];
                w_clip[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int o = 0; o < 2; o++)
                for (int t = 0; t < 8; t++) r_p[o][t] <= '0;
            for (int i = 0; i < 4; i++) r_s[i] <= '0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_byp1 <= 1'b0;
            r_a2   <= '0;
            r_b2   <= '0;
            r_byp2 <= 1'b0;
            r_oa   <= '0;
            r_ob   <= '0;
        end else if (i_en) begin
            // S1
            for (int o = 0; o < 2; o++)
                for (int t = 0; t < 8; t++) r_p[o][t] <= w_p[o][t];
            r_a1   <= i_a;
            r_b1   <= i_b;
            r_byp1 <= i_bypass;
            // S2
            for (int i = 0; i < 4; i++) r_s[i] <= w_s[i];
            r_a2   <= r_a1;
            r_b2   <= r_b1;
            r_byp2 <= r_byp1;
            // S3: bypass lanes carry the original amplitudes bit-exact
            r_oa   <= r_byp2 ? r_a2 : {w_q[0], w_q[1]};
            r_ob   <= r_byp2 ? r_b2 : {w_q[2], w_q[3]};
        end
    end

    assign o_a   = r_oa;
    assign o_b   = r_ob;
    assign o_sat = !r_byp2 && (|w_clip);
endmodule

module gate_apply_array #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15,
    parameter int LANES  = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_coef_load,
    input  logic [8*DATA_W-1:0]          i_coef_in,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [LANES*2*DATA_W-1:0]    i_in_a,
    input  logic [LANES*2*DATA_W-1:0]    i_in_b,
    input  logic [LANES-1:0]             i_in_bypass,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [LANES*2*DATA_W-1:0]    o_out_a,
    output logic [LANES*2*DATA_W-1:0]    o_out_b,
    output logic                         o_sat_flag,
    input  logic                         i_sat_clear,
    output logic                         o_busy
);
    localparam int STAGES = 3;

    logic [8*DATA_W-1:0]               r_coef;
    logic [STAGES:1]                   r_vld_pipe;
    logic                              r_sat;
    logic                              w_en;
    logic [LANES-1:0]                  w_sat;
    logic [LANES-1:0][2*DATA_W-1:0]    w_a, w_b, w_oa, w_ob;

    // One global enable: the whole pipe moves unless S3 is stuck.
    assign w_en       = !r_vld_pipe[STAGES] || i_out_ready;
    assign o_in_ready = w_en;
    assign w_a        = i_in_a;
    assign w_b        = i_in_b;

    // S1 samples r_coef before this edge's load, so a beat accepted together
    // with i_coef_load still sees the old matrix.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)             r_coef <= '0;
        else if (i_coef_load)  r_coef <= i_coef_in;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_vld_pipe <= '0;
        else if (w_en) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_in_valid};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_sat <= 1'b0;
        else if (i_sat_clear)
            r_sat <= 1'b0;
        else if (w_en && r_vld_pipe[STAGES-1] && (|w_sat))
            r_sat <= 1'b1;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gate_apply_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_en     (w_en),
            .i_coef   (r_coef),
            .i_a      (w_a[k]),
            .i_b      (w_b[k]),
            .i_bypass (i_in_bypass[k]),
            .o_a      (w_oa[k]),
            .o_b      (w_ob[k]),
            .o_sat    (w_sat[k])
        );
    end

    assign o_out_a     = w_oa;
    assign o_out_b     = w_ob;
    assign o_out_valid = r_vld_pipe[STAGES];
    assign o_sat_flag  = r_sat;
    assign o_busy      = |r_vld_pipe;
endmodule

// File: tb/tb_gate_apply_array.sv
// Bench for gate_apply_array (DATA_W=16, FRAC_W=15, LANES=4): directed
// test-plan cases plus a randomized stream, scored against a complex
// arithmetic reference model and an in-order expected-beat queue.
module tb_gate_apply_array;
    localparam int DW = 16;
    localparam int FW = 15;
    localparam int L  = 4;
    localparam int BW = L * 2 * DW;
    localparam longint MAXL = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINL = -(longint'(1) <<< (DW - 1));

    localparam logic [8*DW-1:0] PX = {16'h0000, 16'h0000, 16'h7FFF, 16'h0000,
                                      16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [8*DW-1:0] HD = {16'h5A82, 16'h0000, 16'h5A82, 16'h0000,
                                      16'h5A82, 16'h0000, 16'hA57E, 16'h0000};
    localparam logic [8*DW-1:0] ST = {16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
                                      64'h0};
    localparam logic [8*DW-1:0] SN = {16'h8000, 16'h0000, 96'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coef_load = 1'b0;
    logic [8*DW-1:0] coef_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_a = '0, in_b = '0;
    logic [L-1:0]  in_bypass = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_a, out_b;
    logic          sat_flag;
    logic          sat_clear = 1'b0;
    logic          busy;

    gate_apply_array #(.DATA_W(DW), .FRAC_W(FW), .LANES(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_coef_load(coef_load), .i_coef_in(coef_in),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
        .i_in_bypass(in_bypass), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_a(out_a), .o_out_b(out_b), .o_sat_flag(sat_flag),
        .i_sat_clear(sat_clear), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        int            acc;
    } beat_t;

    beat_t         q[$];
    int            pop_log[$];
    logic [8*DW-1:0] m_cur = '0;
    bit            sat_m = 1'b0;
    bit            acc_flag;
    int            cyc = 0;
    int            n_tests = 0, n_fail = 0;
    logic [BW-1:0] last_a, last_b;
    int            last_lat;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint cs(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // {clamped, value}: round half up at FW fractional bits, saturate to DW.
    function automatic logic [DW:0] rsat(input longint x);
        longint y;
        y = (x + (longint'(1) <<< (FW - 1))) >>> FW;
        if (y > MAXL) return {1'b1, DW'(MAXL)};
        if (y < MINL) return {1'b1, DW'(MINL)};
        return {1'b0, DW'(y)};
    endfunction

    task automatic model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [L-1:0] byp,
                         output logic [BW-1:0] oa, output logic [BW-1:0] ob);
        longint u[8];
        longint ar, ai, br, bi;
        logic [DW:0] r[4];
        for (int j = 0; j < 8; j++) u[j] = cs(m_cur[(7-j)*DW +: DW]);
        oa = '0;
        ob = '0;
        for (int k = 0; k < L; k++) begin
            if (byp[k]) begin
                oa[k*2*DW +: 2*DW] = a[k*2*DW +: 2*DW];
                ob[k*2*DW +: 2*DW] = b[k*2*DW +: 2*DW];
            end else begin
                ar = cs(a[k*2*DW+DW +: DW]);  ai = cs(a[k*2*DW +: DW]);
                br = cs(b[k*2*DW+DW +: DW]);  bi = cs(b[k*2*DW +: DW]);
                r[0] = rsat(u[0]*ar - u[1]*ai + u[2]*br - u[3]*bi);
                r[1] = rsat(u[0]*ai + u[1]*ar + u[2]*bi + u[3]*br);
                r[2] = rsat(u[4]*ar - u[5]*ai + u[6]*br - u[7]*bi);
                r[3] = rsat(u[4]*ai + u[5]*ar + u[6]*bi + u[7]*br);
                for (int i = 0; i < 4; i++) if (r[i][DW]) sat_m = 1'b1;
                oa[k*2*DW +: 2*DW] = {r[0][DW-1:0], r[1][DW-1:0]};
                ob[k*2*DW +: 2*DW] = {r[2][DW-1:0], r[3][DW-1:0]};
            end
        end
    endtask

    // Decide what the coming edge transfers, score outputs, update model.
    task automatic monitor();
        beat_t e;
        acc_flag = 1'b0;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                chk("out_a", out_a, q[0].a);
                chk("out_b", out_b, q[0].b);
                if (out_ready) begin
                    last_a   = q[0].a;
                    last_b   = q[0].b;
                    last_lat = cyc - q[0].acc;
                    pop_log.push_back(cyc);
                    void'(q.pop_front());
                end
            end
        end
        if (in_valid && in_ready) begin
            model(in_a, in_b, in_bypass, e.a, e.b);
            e.acc = cyc;
            q.push_back(e);
            acc_flag = 1'b1;
        end
        if (coef_load) m_cur = coef_in;
        if (sat_clear) sat_m = 1'b0;
        cyc++;
    endtask

    // Inputs are set at negedge+1; sample at negedge+2, return at next negedge+1.
    task automatic step();
        #1;
        monitor();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (q.size() != 0 || busy); i++) step();
        chk("drain_left", q.size(), 0);
    endtask

    task automatic load(input logic [8*DW-1:0] m);
        coef_in   = m;
        coef_load = 1'b1;
        step();
        coef_load = 1'b0;
    endtask

    task automatic one(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [L-1:0] byp);
        in_a      = a;
        in_b      = b;
        in_bypass = byp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("one_acc", acc_flag, 1'b1);
        in_valid = 1'b0;
        drain();
    endtask

    function automatic logic [BW-1:0] rnd_bw();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] ta, tb;
        logic [BW-1:0] bp_a[5], bp_b[5];
        int sent;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_sat", sat_flag, 1'b0);
        chk("rst_out_a", out_a, '0);
        chk("rst_out_b", out_b, '0);

        // Pauli-X
        load(PX);
        ta = rnd_bw(); tb = rnd_bw();
        ta[31:0] = 32'h40000000;
        tb[31:0] = 32'h00002000;
        one(ta, tb, 4'b0000);
        chk("px_a0", last_a[31:0], 32'h00002000);
        chk("px_b0", last_b[31:0], 32'h40000000);
        chk("px_lat", last_lat, 3);
        chk("px_sat", sat_flag, 1'b0);

        // Hadamard
        load(HD);
        ta = '0; tb = '0;
        ta[31:0] = 32'h7FFF0000;
        one(ta, tb, 4'b0000);
        chk("hd_a0", last_a[31:0], 32'h5A810000);
        chk("hd_b0", last_b[31:0], 32'h5A810000);
        chk("hd_sat", sat_flag, 1'b0);

        // Saturation, positive overflow then clear
        load(ST);
        ta = '0; tb = '0;
        ta[31:0] = 32'h7FFF0000;
        tb[31:0] = 32'h7FFF0000;
        one(ta, tb, 4'b0000);
        chk("st_a0", last_a[31:0], 32'h7FFF0000);
        chk("st_flag", sat_flag, 1'b1);
        chk("st_model", sat_flag, sat_m);
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        chk("st_clear", sat_flag, 1'b0);

        // (-1)*(-1) overflows to +1
        load(SN);
        ta = '0; tb = '0;
        ta[31:0] = 32'h80000000;
        one(ta, tb, 4'b0000);
        chk("sn_a0", last_a[31:0], 32'h7FFF0000);
        chk("sn_flag", sat_flag, 1'b1);
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;

        // Bypass lanes 0 and 2 under Pauli-X
        load(PX);
        ta = rnd_bw(); tb = rnd_bw();
        one(ta, tb, 4'b0101);
        chk("byp_a0", last_a[31:0], ta[31:0]);
        chk("byp_b0", last_b[31:0], tb[31:0]);
        chk("byp_a2", last_a[95:64], ta[95:64]);
        chk("byp_b2", last_b[95:64], tb[95:64]);

        // Saturating data on bypassed lanes only
        load(ST);
        ta = '0; tb = '0;
        ta[31:0] = 32'h7FFF7FFF;  tb[31:0] = 32'h7FFF7FFF;
        ta[95:64] = 32'h7FFF7FFF; tb[95:64] = 32'h7FFF7FFF;
        one(ta, tb, 4'b0101);
        chk("byp_nosat", sat_flag, 1'b0);
        chk("byp_a0_st", last_a[31:0], 32'h7FFF7FFF);

        // Backpressure: exactly three beats fit
        load(PX);
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = rnd_bw();
            bp_b[i] = rnd_bw();
        end
        pop_log.delete();
        sent      = 0;
        out_ready = 1'b0;
        in_bypass = '0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = bp_a[sent];
            in_b     = bp_b[sent];
            step();
            if (acc_flag) sent++;
        end
        chk("bp_accepted", sent, 3);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sent < 5; i++) begin
            in_valid = 1'b1;
            in_a     = bp_a[sent];
            in_b     = bp_b[sent];
            step();
            if (acc_flag) sent++;
        end
        drain();
        chk("bp_pops", pop_log.size(), 5);
        if (pop_log.size() == 5) chk("bp_gapless", pop_log[4] - pop_log[0], 4);

        // Matrix switch in the cycle beat 2 is accepted
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_a      = rnd_bw();
            in_b      = rnd_bw();
            coef_load = (i == 2);
            coef_in   = HD;
            step();
            chk("sw_acc", acc_flag, 1'b1);
        end
        coef_load = 1'b0;
        drain();
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;

        // Reset with three beats in flight
        load(PX);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = rnd_bw();
            in_b     = rnd_bw();
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_out_a", out_a, '0);
        q.delete();
        m_cur = '0;
        sat_m = 1'b0;
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("mr_idle_busy", busy, 1'b0);
        ta = rnd_bw(); tb = rnd_bw();
        one(ta, tb, 4'b0000);
        chk("mr_zero_mat", last_a, '0);

        // Randomized stream
        for (int i = 0; i < 500; i++) begin
            coef_load = ($urandom_range(0, 15) == 0);
            coef_in   = {$urandom, $urandom, $urandom, $urandom};
            if (!in_valid || acc_flag) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_a      = rnd_bw();
                in_b      = rnd_bw();
                in_bypass = L'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        coef_load = 1'b0;
        drain();
        chk("rnd_sat", sat_flag, sat_m);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
